inst_rom: RTL
=============

// Module: inst_rom
// PURPOSE
// - Instruction-memory responder on the fetch interface: serves the 32-bit word at the fetch address (pc/ce) driven by the PC stage.
// - Models configurable wait-state memory; raises stallreq to CTRL until the requested word is valid, freezing PC and IF.
// - Sits between the PC register and IF/ID; holds a one-entry served-word register (tag + data).
// PARAMETERS
// - ADDR_W       10      word-address bits; depth = 2**ADDR_W words
// - WAIT_CYCLES  2       extra access cycles per miss, 0..15
// PORTS
// - clk        in   1    single clock, all state on posedge
// - rst        in   1    synchronous, active-high reset
// - ce         in   1    fetch chip enable from PC stage; 0 = no request
// - pc         in   32   fetch byte address
// - inst       out  32   instruction word to IF/ID
// - inst_valid out  1    inst belongs to the current pc
// - stallreq   out  1    stall request to CTRL (drives stall[0])
// - addr_err   out  1    pc[1:0]!=0 for the served word
// - we/waddr/wdata in 1/32/32   loader write port, only with INST_ROM_WR_EN
// BEHAVIOUR
// - Interface: one clock, clk; synchronous active-high reset, rst.
// - Reset: state=IDLE, cnt=0, inst=0, served_valid=0, served_pc=0, addr_err=0; outputs inst_valid=0, stallreq=0. Memory contents not reset.
// - hit  = ce & served_valid & (pc==served_pc); miss = ce & ~hit.
// - stallreq = miss (combinational); inst_valid = hit; inst/addr_err are registers.
// - FSM IDLE:
//   - miss & pc[1:0]!=0: capture now: inst<=0 (nop), addr_err<=1, served_pc<=pc, served_valid<=1; no wait states.
//   - miss & aligned & WAIT_CYCLES==0: inst<=mem[pc[ADDR_W+1:2]], addr_err<=0, served_*<=pc/1; stay IDLE.
//   - miss & aligned & WAIT_CYCLES>0: req_pc<=pc, cnt<=WAIT_CYCLES-1, ->BUSY.
//   - hit or ce=0: hold.
// - FSM BUSY:
//   - ce=0: abort ->IDLE, served_valid<=0.
//   - pc!=req_pc (redirect): req_pc<=pc, cnt<=WAIT_CYCLES-1, stay BUSY; misaligned redirect is captured as in IDLE, ->IDLE.
//   - cnt!=0: cnt<=cnt-1.
//   - cnt==0: inst<=mem[req_pc[ADDR_W+1:2]], addr_err<=0, served_pc<=req_pc, served_valid<=1, ->IDLE.
// - Latency: first miss cycle at T -> hit (stallreq=0, inst_valid=1) at T+WAIT_CYCLES+1; misaligned -> T+1.
// - Address wrap: pc bits above ADDR_W+1 ignored (pc=4<<ADDR_W aliases word 0); served_pc tag compares all 32 bits.
// - rst has priority over every other event, including mid-BUSY; the access is dropped.
// CONFIGURATION
// - INST_ROM_WR_EN defined: we/waddr/wdata exist; we=1 writes mem[waddr[ADDR_W+1:2]]<=wdata on posedge.
//   - Write whose word index equals served_pc's: served_valid<=0 (refetch).
//   - Same-cycle write and capture of that word: capture returns old data, served_valid ends 0.
// - INST_ROM_WR_EN undefined: no write ports; memory is preloaded by the bench through hierarchical access only.
// TESTING
// - rst=1 for 3 cycles, ce=0 -> inst=0, inst_valid=0, stallreq=0, addr_err=0.
// - WAIT=2, mem[0]=32'h34010001, ce=1, pc=0 at T -> stallreq=1 at T..T+2; T+3 inst=32'h34010001, inst_valid=1, stallreq=0.
// - Sequential pc 0,4,8 advancing on ~stallreq -> each word stalls 3 cycles, returns mem[0],mem[1],mem[2] in order.
// - pc=32'h2 -> T+1 addr_err=1, inst=0, inst_valid=1; stallreq only at T.
// - Redirect pc 0->32'h40 at T+1 during BUSY -> hit at T+4, inst=mem[16]; rst at T+2 of another access -> T+3 all outputs at reset values.
// - INST_ROM_WR_EN: served pc=0 hit, write 32'hDEADBEEF to waddr=0 -> next cycle inst_valid=0, stallreq=1; 3 cycles later inst=32'hDEADBEEF.

Source files
------------

// File: rtl/inst_rom.sv
// Instruction memory on the fetch path with configurable wait states and a one-entry served-word tag.
// Optional loader write port enabled by defining INST_ROM_WR_EN.
module inst_rom #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic [31:0] pc,
`ifdef INST_ROM_WR_EN
  input  logic        we,
  input  logic [31:0] waddr,
  input  logic [31:0] wdata,
`endif
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        stallreq,
  output logic        addr_err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  localparam logic [3:0] RELOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [31:0] mem [0:DEPTH-1];

  logic [0:0]  state_r, state_n;
  logic [3:0]  cnt_r, cnt_n;
  logic [31:0] req_pc_r, req_pc_n;
  logic [31:0] served_pc_r, served_pc_n;
  logic        served_valid_r, served_valid_n;
  logic [31:0] inst_r, inst_n;
  logic        addr_err_r, addr_err_n;
  logic        hit_s, miss_s;

  assign hit_s      = ce & served_valid_r & (pc == served_pc_r);
  assign miss_s     = ce & ~hit_s;
  assign stallreq   = miss_s;
  assign inst_valid = hit_s;
  assign inst       = inst_r;
  assign addr_err   = addr_err_r;

  // Next-state logic for the access FSM and served-word register
  always_comb begin
    state_n        = state_r;
    cnt_n          = cnt_r;
    req_pc_n       = req_pc_r;
    served_pc_n    = served_pc_r;
    served_valid_n = served_valid_r;
    inst_n         = inst_r;
    addr_err_n     = addr_err_r;
    case (state_r)
      IDLE: begin
        if (miss_s) begin
          if (pc[1:0] != 2'b00) begin
            inst_n         = 32'd0;
            addr_err_n     = 1'b1;
            served_pc_n    = pc;
            served_valid_n = 1'b1;
          end else if (WAIT_CYCLES == 0) begin
            inst_n         = mem[pc[ADDR_W+1:2]];
            addr_err_n     = 1'b0;
            served_pc_n    = pc;
            served_valid_n = 1'b1;
          end else begin
            req_pc_n = pc;
            cnt_n    = RELOAD;
            state_n  = BUSY;
          end
        end else begin
          state_n = IDLE;
        end
      end
      BUSY: begin
        if (!ce) begin
          state_n        = IDLE;
          served_valid_n = 1'b0;
        end else if (pc != req_pc_r) begin
          // A misaligned redirect completes immediately as a nop
          if (pc[1:0] != 2'b00) begin
            inst_n         = 32'd0;
            addr_err_n     = 1'b1;
            served_pc_n    = pc;
            served_valid_n = 1'b1;
            state_n        = IDLE;
          end else begin
            req_pc_n = pc;
            cnt_n    = RELOAD;
          end
        end else if (cnt_r != 4'd0) begin
          cnt_n = cnt_r - 4'd1;
        end else begin
          inst_n         = mem[req_pc_r[ADDR_W+1:2]];
          addr_err_n     = 1'b0;
          served_pc_n    = req_pc_r;
          served_valid_n = 1'b1;
          state_n        = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
`ifdef INST_ROM_WR_EN
    // A write to the served (or just-captured) word forces a refetch
    if (we && (waddr[ADDR_W+1:2] == served_pc_n[ADDR_W+1:2])) begin
      served_valid_n = 1'b0;
    end else begin
      served_valid_n = served_valid_n;
    end
`endif
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      cnt_r          <= 4'd0;
      req_pc_r       <= 32'd0;
      served_pc_r    <= 32'd0;
      served_valid_r <= 1'b0;
      inst_r         <= 32'd0;
      addr_err_r     <= 1'b0;
    end else begin
      state_r        <= state_n;
      cnt_r          <= cnt_n;
      req_pc_r       <= req_pc_n;
      served_pc_r    <= served_pc_n;
      served_valid_r <= served_valid_n;
      inst_r         <= inst_n;
      addr_err_r     <= addr_err_n;
    end
  end

`ifdef INST_ROM_WR_EN
  // Loader write port; reads in the same cycle still see the old word
  always_ff @(posedge clk) begin
    if (we && !rst) begin
      mem[waddr[ADDR_W+1:2]] <= wdata;
    end
  end
`endif

endmodule
